// File: rtl/fir_sample_streamer_if.sv
// FIR-side link of the sample streamer: strobe and sample toward the FIR,
// result strobe and value back from it.
interface fir_sample_streamer_if #(
  parameter int SW = 16,
  parameter int YW = 32
);
  logic                 fir_valid_o;
  logic signed [SW-1:0] fir_sample_o;
  logic                 fir_valid_i;
  logic signed [YW-1:0] fir_y_i;

  modport master (
    output fir_valid_o,
    output fir_sample_o,
    input  fir_valid_i,
    input  fir_y_i
  );

  modport slave (
    input  fir_valid_o,
    input  fir_sample_o,
    output fir_valid_i,
    output fir_y_i
  );
endinterface

// File: rtl/fir_sample_streamer.sv
// Plays a preloaded sample table into a FIR one strobe at a time, waits for each
// result and stores it in a result RAM readable with one cycle of latency.
module fir_sample_streamer #(
  parameter int DEPTH   = 1024,
  parameter int AW      = $clog2(DEPTH),
  parameter int SW      = 16,
  parameter int YW      = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [AW:0]          len_i,
  input  logic                 ld_we_i,
  input  logic [AW-1:0]        ld_addr_i,
  input  logic signed [SW-1:0] ld_data_i,
  fir_sample_streamer_if.master fir,
  input  logic [AW-1:0]        res_addr_i,
  output logic signed [YW-1:0] res_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [AW:0]          count_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_STROBE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [AW:0]          len_q, len_d;
  logic [AW:0]          idx_q, idx_d;
  logic [CW-1:0]        wcnt_q, wcnt_d;
  logic                 timeout_q, timeout_d;
  logic                 res_we;
  logic signed [SW-1:0] sample_q;
  logic signed [YW-1:0] res_q;

  logic signed [SW-1:0] tbl_mem [DEPTH];
  logic signed [YW-1:0] res_mem [DEPTH];

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    if (l > (AW+1)'(DEPTH)) return (AW+1)'(DEPTH);
    return l;
  endfunction

  // A zero-length run still passes through FETCH so that done_o lands two
  // cycles after start, matching the strobe latency of a real run.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    res_we    = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_d     = clamp_len(len_i);
            idx_d     = '0;
            timeout_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH:  state_d = (len_q == '0) ? S_DONE : S_STROBE;
        S_STROBE: begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (fir.fir_valid_i) begin
            res_we  = 1'b1;
            idx_d   = idx_q + (AW+1)'(1);
            state_d = (idx_q + (AW+1)'(1) == len_q) ? S_DONE : S_FETCH;
          end else if (wcnt_q == CW'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      sample_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      if (state_q == S_FETCH && state_d == S_STROBE) sample_q <= tbl_mem[idx_q[AW-1:0]];
      res_q <= res_mem[res_addr_i];
    end
  end

  // Storage arrays carry no reset; the table only accepts writes while idle.
  always_ff @(posedge clk_i) begin
    if (ld_we_i && state_q == S_IDLE) tbl_mem[ld_addr_i] <= ld_data_i;
    if (res_we) res_mem[idx_q[AW-1:0]] <= fir.fir_y_i;
  end

  assign fir.fir_valid_o  = (state_q == S_STROBE);
  assign fir.fir_sample_o = sample_q;
  assign res_data_o       = res_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign timeout_o        = timeout_q;
  assign count_o          = idx_q;

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Bench for fir_sample_streamer: a delayed y=2*x FIR model, a reference sample table,
// table-driven runs, random runs and hand-written timing sequences.
module tb_fir_sample_streamer;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int SW    = 16;
  localparam int YW    = 32;
  localparam int TO    = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, tb_abort, ld_we, stray_vld;
  logic [AW:0]          len;
  logic [AW-1:0]        ld_addr, res_addr;
  logic signed [SW-1:0] ld_data;
  logic signed [YW-1:0] res_data;
  logic                 busy, done, tmo;
  logic [AW:0]          cnt;

  logic                 model_vld, model_abort;
  logic signed [YW-1:0] model_y;

  fir_sample_streamer_if #(.SW(SW), .YW(YW)) fif ();
  assign fif.fir_valid_i = model_vld | stray_vld;
  assign fif.fir_y_i     = model_y;

  fir_sample_streamer #(.DEPTH(DEPTH), .AW(AW), .SW(SW), .YW(YW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(tb_abort | model_abort),
    .len_i(len), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .fir(fif), .res_addr_i(res_addr), .res_data_o(res_data),
    .busy_o(busy), .done_o(done), .timeout_o(tmo), .count_o(cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIR model: answers each strobe with 2*x after a fixed or random delay.
  bit                   resp_en = 1'b1;
  int                   delay_mode = 3;
  int                   abort_at = 0;
  int                   resp_n = 0;
  int                   abort_cyc = -1;
  logic signed [SW-1:0] strobe_log [$];

  initial begin
    bit                   pend;
    int                   cd;
    logic signed [SW-1:0] x;
    logic signed [YW-1:0] e;
    pend = 1'b0; cd = 0; x = '0;
    model_vld = 1'b0; model_abort = 1'b0; model_y = '0;
    forever begin
      @(negedge clk);
      model_vld   = 1'b0;
      model_abort = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 1'b0;
          resp_n++;
          e = x;
          model_y   = e + e;
          model_vld = 1'b1;
          if (resp_n == abort_at) begin
            model_abort = 1'b1;
            abort_cyc   = cyc;
          end
        end
      end
      if (fif.fir_valid_o) begin
        strobe_log.push_back(fif.fir_sample_o);
        if (resp_en) begin
          pend = 1'b1;
          x    = fif.fir_sample_o;
          cd   = (delay_mode > 0) ? delay_mode : int'($urandom_range(1, 5));
        end
      end
    end
  end

  logic signed [SW-1:0] ref_tbl [DEPTH];
  int passed = 0;
  int total  = 0;

  function automatic logic signed [YW-1:0] dbl(input logic signed [SW-1:0] v);
    logic signed [YW-1:0] w;
    w = v;
    return w * 2;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_ref(input int a, input logic signed [SW-1:0] v);
    ld_we = 1'b1; ld_addr = AW'(a); ld_data = v;
    step();
    ld_we = 1'b0;
    ref_tbl[a] = v;
  endtask

  task automatic start_run(input int l);
    start = 1'b1; len = (AW+1)'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      total++;
      $display("FAIL %s: no done_o within %0d cycles", name, budget);
    end
  endtask

  task automatic read_res(input int a, output logic signed [YW-1:0] v);
    res_addr = AW'(a);
    step();
    v = res_data;
  endtask

  task automatic check_run(input string name, input int n_res, input int n_strobe);
    logic signed [YW-1:0] y;
    int bad;
    chk({name, " strobes"}, strobe_log.size(), n_strobe);
    bad = 0;
    for (int k = 0; k < strobe_log.size() && k < n_strobe; k++)
      if (strobe_log[k] != ref_tbl[k]) bad++;
    chk({name, " sample mismatches"}, bad, 0);
    for (int k = 0; k < n_res; k++) begin
      read_res(k, y);
      chk($sformatf("%s res[%0d]", name, k), y, dbl(ref_tbl[k]));
    end
  endtask

  typedef struct {
    int     len;
    int     delay;
    int     base;
    int     stp;
    int     exp_cnt;
    int     exp_strobes;
    bit     exp_to;
    longint exp_y0;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit                   ok, seen_done;
    logic signed [YW-1:0] y;
    string                nm;
    int                   n, bad;

    vecs[0] = '{4, 3,   1,   1, 4, 4, 1'b0,   2};
    vecs[1] = '{1, 1,  -3,   0, 1, 1, 1'b0,  -6};
    vecs[2] = '{6, 5, 100, -50, 6, 6, 1'b0, 200};
    vecs[3] = '{3, 0,   7,   1, 0, 1, 1'b1,   0};
    vecs[4] = '{0, 2,   9,   1, 0, 0, 1'b0,   0};

    rst = 1'b1; start = 1'b0; tb_abort = 1'b0; ld_we = 1'b0; stray_vld = 1'b1;
    len = '0; ld_addr = '0; ld_data = '0; res_addr = '0;

    // Reset, with a stray FIR result strobe held high throughout.
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst timeout", tmo, 0);
    chk("rst count", cnt, 0);
    chk("rst fir_valid", fif.fir_valid_o, 0);
    chk("rst fir_sample", fif.fir_sample_o, 0);
    chk("rst res_data", res_data, 0);
    rst = 1'b0;
    step(); step();
    chk("idle stray busy", busy, 0);
    chk("idle stray count", cnt, 0);
    stray_vld = 1'b0;

    // Table-driven runs.
    foreach (vecs[v]) begin
      nm = $sformatf("vec%0d", v);
      resp_en = (vecs[v].delay != 0);
      delay_mode = vecs[v].delay;
      for (int i = 0; i < vecs[v].len; i++)
        load_ref(i, SW'(vecs[v].base + i * vecs[v].stp));
      strobe_log.delete();
      start_run(vecs[v].len);
      wait_done(200, nm, ok);
      step();
      chk({nm, " done one cycle"}, done, 0);
      chk({nm, " busy after"}, busy, 0);
      chk({nm, " count"}, cnt, vecs[v].exp_cnt);
      chk({nm, " timeout"}, tmo, vecs[v].exp_to);
      check_run(nm, vecs[v].exp_cnt, vecs[v].exp_strobes);
      if (vecs[v].exp_cnt > 0) begin
        read_res(0, y);
        chk({nm, " res0 const"}, y, vecs[v].exp_y0);
      end
    end

    // Strobe latency from start and from a capture.
    resp_en = 1'b1; delay_mode = 3;
    load_ref(0, 16'sd11); load_ref(1, 16'sd22);
    start_run(2);
    chk("lat start+1 strobe", fif.fir_valid_o, 0);
    step();
    chk("lat start+2 strobe", fif.fir_valid_o, 1);
    step(); step(); step(); step();
    chk("lat capture+1 strobe", fif.fir_valid_o, 0);
    step();
    chk("lat capture+2 strobe", fif.fir_valid_o, 1);
    chk("lat 2nd sample", fif.fir_sample_o, 22);
    wait_done(50, "lat run", ok);

    // Zero-length run timing.
    step();
    strobe_log.delete();
    start_run(0);
    chk("len0 start+1 done", done, 0);
    chk("len0 start+1 busy", busy, 1);
    step();
    chk("len0 start+2 done", done, 1);
    chk("len0 count", cnt, 0);
    step();
    chk("len0 strobes", strobe_log.size(), 0);

    // Timeout timing, then the next start clears the flag.
    resp_en = 1'b0;
    start_run(3);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fif.fir_valid_o) begin ok = 1'b1; break; end
      step();
    end
    chk("to strobe seen", ok, 1);
    seen_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("to early done", seen_done, 0);
    step();
    chk("to done at wait+16", done, 1);
    chk("to flag", tmo, 1);
    chk("to count", cnt, 0);
    step();
    chk("to flag sticky", tmo, 1);
    resp_en = 1'b1;
    start_run(1);
    chk("to cleared by start", tmo, 0);
    wait_done(50, "to next run", ok);
    chk("to next count", cnt, 1);

    // Abort coinciding with the third result.
    step();
    for (int i = 0; i < 8; i++) load_ref(i, SW'(10 + i));
    strobe_log.delete();
    start_run(8);
    wait_done(200, "abort prep", ok);
    step();
    for (int i = 0; i < 8; i++) load_ref(i, SW'(500 + i));
    resp_n = 0; abort_at = 3;
    start_run(8);
    seen_done = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) seen_done = 1'b1;
      if (!busy) begin ok = 1'b1; break; end
    end
    abort_at = 0;
    chk("abort idle reached", ok, 1);
    chk("abort idle next cycle", cyc, abort_cyc + 1);
    chk("abort no done", seen_done, 0);
    chk("abort count", cnt, 2);
    read_res(2, y);
    chk("abort res[2] kept", y, 24);
    read_res(1, y);
    chk("abort res[1] new", y, 1002);
    step(); step();
    chk("abort still idle", busy, 0);
    chk("abort later done", done, 0);

    // Randomized runs against the reference table.
    for (int r = 0; r < 4; r++) begin
      nm = $sformatf("rnd%0d", r);
      n = int'($urandom_range(1, 24));
      delay_mode = -1;
      for (int i = 0; i < n; i++) load_ref(i, SW'($urandom));
      strobe_log.delete();
      start_run(n);
      wait_done(400, nm, ok);
      step();
      chk({nm, " count"}, cnt, n);
      chk({nm, " timeout"}, tmo, 0);
      check_run(nm, n, n);
    end

    // Full-depth run with a clamped length; table write and start while busy.
    delay_mode = 1;
    for (int i = 0; i < DEPTH; i++) load_ref(i, SW'($urandom));
    strobe_log.delete();
    start_run(2000);
    for (int i = 0; i < 20; i++) step();
    ld_we = 1'b1; ld_addr = '0; ld_data = 16'sh7EEF;
    start = 1'b1; len = (AW+1)'(5);
    step();
    ld_we = 1'b0; start = 1'b0;
    wait_done(20000, "long run", ok);
    step();
    chk("long count", cnt, DEPTH);
    chk("long strobes", strobe_log.size(), DEPTH);
    bad = 0;
    for (int k = 0; k < strobe_log.size(); k++)
      if (strobe_log[k] != ref_tbl[k]) bad++;
    chk("long sample mismatches", bad, 0);
    for (int k = 0; k < DEPTH; k += 97) begin
      read_res(k, y);
      chk($sformatf("long res[%0d]", k), y, dbl(ref_tbl[k]));
    end
    read_res(DEPTH - 1, y);
    chk("long res[last]", y, dbl(ref_tbl[DEPTH-1]));
    strobe_log.delete();
    start_run(1);
    wait_done(50, "table0 probe", ok);
    step();
    chk("table0 unchanged", strobe_log.size() > 0 ? strobe_log[0] : 16'sh7EEF, ref_tbl[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
